// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared FSM state encoding and default widths for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_addr_w   = 10;
    localparam int c_data_w   = 32;
    localparam int c_starve_w = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        EXT_RD  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Core, external-master and RAM signals around the dmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);

    logic              CORE_READ;
    logic              CORE_WRITE;
    logic [ADDR_W-1:0] CORE_ADDR;
    logic [DATA_W-1:0] CORE_WDATA;
    logic [DATA_W-1:0] CORE_RDATA;
    logic              CORE_STALL;

    logic              EXT_REQ;
    logic              EXT_WE;
    logic [ADDR_W-1:0] EXT_ADDR;
    logic [DATA_W-1:0] EXT_WDATA;
    logic              EXT_GNT;
    logic              EXT_RVALID;
    logic [DATA_W-1:0] EXT_RDATA;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [DATA_W-1:0] MEM_RDATA;

    // Arbiter side
    modport slave (
        input  CORE_READ, CORE_WRITE, CORE_ADDR, CORE_WDATA,
        input  EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA,
        input  MEM_RDATA,
        output CORE_RDATA, CORE_STALL,
        output EXT_GNT, EXT_RVALID, EXT_RDATA,
        output MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE
    );

    // Requester / RAM side
    modport master (
        output CORE_READ, CORE_WRITE, CORE_ADDR, CORE_WDATA,
        output EXT_REQ, EXT_WE, EXT_ADDR, EXT_WDATA,
        output MEM_RDATA,
        input  CORE_RDATA, CORE_STALL,
        input  EXT_GNT, EXT_RVALID, EXT_RDATA,
        input  MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : starve_counter
// Brief    : Saturating up-counter with synchronous clear and runtime limit.
// Revision : 1.0 - initial release
// ============================================================================
module starve_counter
    import dmem_arb_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_inc,
    input  wire logic                  i_clr,
    input  wire logic [c_starve_w-1:0] i_limit,
    output logic      [c_starve_w-1:0] o_count
);

    logic [c_starve_w-1:0] count_q;
    logic [c_starve_w-1:0] count_d;

    // Clear dominates increment so a grant always restarts the count.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q < i_limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Core / external-master arbiter and load sequencer for the
//            single-port synchronous-read data RAM.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_addr_w,
    parameter int DATA_W       = c_data_w,
    parameter int STARVE_LIMIT = 4
)(
    input  wire logic     CLK,
    input  wire logic     RESET_N,
    dmem_arbiter_if.slave bus
);

    localparam logic [c_starve_w-1:0] c_limit = c_starve_w'(STARVE_LIMIT);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [DATA_W-1:0]     core_rdata_q;
    logic [DATA_W-1:0]     core_rdata_d;
    logic [DATA_W-1:0]     ext_rdata_q;
    logic [DATA_W-1:0]     ext_rdata_d;

    logic [c_starve_w-1:0] starve_count;
    logic                  core_req;
    logic                  ext_wins;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic                  core_stall;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     core_rdata;
    logic [DATA_W-1:0]     ext_rdata;

    always_comb begin
        core_req = bus.CORE_READ | bus.CORE_WRITE;
        ext_wins = bus.EXT_REQ && (!core_req || (starve_count == c_limit));
    end

    starve_counter u_starve (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_inc   (bus.EXT_REQ && !ext_gnt),
        .i_clr   (ext_gnt || !bus.EXT_REQ),
        .i_limit (c_limit),
        .o_count (starve_count)
    );

    always_comb begin
        state_d      = state_q;
        core_rdata_d = core_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        core_rdata   = core_rdata_q;
        ext_rdata    = ext_rdata_q;
        ext_gnt      = 1'b0;
        ext_rvalid   = 1'b0;
        core_stall   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ext_wins) begin
                    ext_gnt    = 1'b1;
                    core_stall = core_req;
                    mem_addr   = bus.EXT_ADDR;
                    mem_wdata  = bus.EXT_WDATA;
                    mem_write  = bus.EXT_WE;
                    mem_read   = !bus.EXT_WE;
                    if (!bus.EXT_WE) begin
                        state_d = EXT_RD;
                    end
                end else if (core_req) begin
                    mem_addr   = bus.CORE_ADDR;
                    mem_write  = bus.CORE_WRITE;
                    mem_read   = bus.CORE_READ;
                    core_stall = bus.CORE_READ;
                    if (bus.CORE_WRITE) begin
                        mem_wdata = bus.CORE_WDATA;
                    end
                    if (bus.CORE_READ) begin
                        state_d = CORE_RD;
                    end
                end
            end
            // The core still presents its load here; it is already served.
            CORE_RD: begin
                core_rdata   = bus.MEM_RDATA;
                core_rdata_d = bus.MEM_RDATA;
                state_d      = IDLE;
            end
            EXT_RD: begin
                ext_rvalid  = 1'b1;
                ext_rdata   = bus.MEM_RDATA;
                ext_rdata_d = bus.MEM_RDATA;
                core_stall  = core_req;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign bus.CORE_RDATA = core_rdata;
    assign bus.CORE_STALL = core_stall;
    assign bus.EXT_GNT    = ext_gnt;
    assign bus.EXT_RVALID = ext_rvalid;
    assign bus.EXT_RDATA  = ext_rdata;
    assign bus.MEM_ADDR   = mem_addr;
    assign bus.MEM_WDATA  = mem_wdata;
    assign bus.MEM_READ   = mem_read;
    assign bus.MEM_WRITE  = mem_write;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ram [0:1023];

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W       (10),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) u_dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle of read latency
    always @(posedge clk) begin
        if (bus.MEM_WRITE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        if (bus.MEM_READ)  bus.MEM_RDATA     <= ram[bus.MEM_ADDR];
    end

    // {EXT_GNT, EXT_RVALID, MEM_WRITE, MEM_READ, CORE_STALL}
    function automatic logic [4:0] ctrl();
        return {bus.EXT_GNT, bus.EXT_RVALID, bus.MEM_WRITE, bus.MEM_READ, bus.CORE_STALL};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.CORE_READ  = 1'b0;
        bus.CORE_WRITE = 1'b0;
        bus.CORE_ADDR  = '0;
        bus.CORE_WDATA = '0;
        bus.EXT_REQ    = 1'b0;
        bus.EXT_WE     = 1'b0;
        bus.EXT_ADDR   = '0;
        bus.EXT_WDATA  = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp %b", ctrl(), 5'b00000);
        end
        checks++;
        if ({bus.CORE_RDATA, bus.EXT_RDATA} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h exp 0", {bus.CORE_RDATA, bus.EXT_RDATA});
        end
        checks++;
        if (bus.MEM_ADDR !== 10'h000) begin
            errors++; $display("FAIL reset_mem_addr: got %h exp 000", bus.MEM_ADDR);
        end
    endtask

    task automatic test_store_load();
        bus.CORE_WRITE = 1'b1; bus.CORE_ADDR = 10'h010; bus.CORE_WDATA = 32'hDEADBEEF;
        #1;
        checks++;
        if (ctrl() !== 5'b00100) begin
            errors++; $display("FAIL store_ctrl: got %b exp %b", ctrl(), 5'b00100);
        end
        checks++;
        if ({bus.MEM_ADDR, bus.MEM_WDATA} !== {10'h010, 32'hDEADBEEF}) begin
            errors++; $display("FAIL store_bus: got %h/%h exp 010/deadbeef", bus.MEM_ADDR, bus.MEM_WDATA);
        end
        tick();
        bus.CORE_WRITE = 1'b0; bus.CORE_READ = 1'b1;
        #1;
        checks++;
        if (ctrl() !== 5'b00011 || bus.MEM_ADDR !== 10'h010) begin
            errors++; $display("FAIL load_issue: got %b/%h exp 00011/010", ctrl(), bus.MEM_ADDR);
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00000 || bus.CORE_RDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_data: got %b/%h exp 00000/deadbeef", ctrl(), bus.CORE_RDATA);
        end
        bus.CORE_READ = 1'b0;
        tick();
        checks++;
        if (bus.CORE_RDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_hold: got %h exp deadbeef", bus.CORE_RDATA);
        end
    endtask

    task automatic test_ext_read();
        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b0; bus.EXT_ADDR = 10'h3FF;
        #1;
        checks++;
        if (ctrl() !== 5'b10010 || bus.MEM_ADDR !== 10'h3FF) begin
            errors++; $display("FAIL ext_rd_gnt: got %b/%h exp 10010/3ff", ctrl(), bus.MEM_ADDR);
        end
        tick();
        bus.EXT_REQ = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b01000 || bus.EXT_RDATA !== 32'h12345678) begin
            errors++; $display("FAIL ext_rd_data: got %b/%h exp 01000/12345678", ctrl(), bus.EXT_RDATA);
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00000 || bus.EXT_RDATA !== 32'h12345678) begin
            errors++; $display("FAIL ext_rd_hold: got %b/%h exp 00000/12345678", ctrl(), bus.EXT_RDATA);
        end
    endtask

    // Ext write held against a core store every cycle: loses 4, wins the 5th.
    task automatic test_contention(input logic [9:0] base);
        logic [4:0] exp_ctrl;
        logic [9:0] exp_addr;
        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b1; bus.EXT_ADDR = 10'h020; bus.EXT_WDATA = 32'hCAFE0001;
        for (int i = 0; i < 5; i++) begin
            bus.CORE_WRITE = 1'b1; bus.CORE_ADDR = base + 10'(i); bus.CORE_WDATA = 32'(i);
            #1;
            exp_ctrl = (i == 4) ? 5'b10101 : 5'b00100;
            exp_addr = (i == 4) ? 10'h020 : base + 10'(i);
            checks++;
            if (ctrl() !== exp_ctrl || bus.MEM_ADDR !== exp_addr) begin
                errors++; $display("FAIL contention_%0d: got %b/%h exp %b/%h", i, ctrl(), bus.MEM_ADDR, exp_ctrl, exp_addr);
            end
            tick();
        end
        bus.EXT_REQ = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b00100 || bus.MEM_ADDR !== base + 10'd4) begin
            errors++; $display("FAIL contention_retry: got %b/%h exp 00100/%h", ctrl(), bus.MEM_ADDR, base + 10'd4);
        end
        tick();
        bus.CORE_WRITE = 1'b0;
    endtask

    task automatic test_load_during_ext_read();
        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b0; bus.EXT_ADDR = 10'h020;
        #1;
        checks++;
        if (ctrl() !== 5'b10010) begin
            errors++; $display("FAIL overlap_gnt: got %b exp 10010", ctrl());
        end
        tick();
        bus.EXT_REQ = 1'b0; bus.CORE_READ = 1'b1; bus.CORE_ADDR = 10'h103;
        #1;
        checks++;
        if (ctrl() !== 5'b01001 || bus.EXT_RDATA !== 32'hCAFE0001) begin
            errors++; $display("FAIL overlap_t1: got %b/%h exp 01001/cafe0001", ctrl(), bus.EXT_RDATA);
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00011 || bus.MEM_ADDR !== 10'h103) begin
            errors++; $display("FAIL overlap_t2: got %b/%h exp 00011/103", ctrl(), bus.MEM_ADDR);
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00000 || bus.CORE_RDATA !== 32'h3) begin
            errors++; $display("FAIL overlap_t3: got %b/%h exp 00000/00000003", ctrl(), bus.CORE_RDATA);
        end
        bus.CORE_READ = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b1;
            bus.EXT_ADDR = 10'h200 + 10'(i); bus.EXT_WDATA = 32'hA0 + 32'(i);
            #1;
            checks++;
            if (ctrl() !== 5'b10100 || bus.MEM_ADDR !== 10'h200 + 10'(i)) begin
                errors++; $display("FAIL b2b_wr_%0d: got %b/%h exp 10100/%h", i, ctrl(), bus.MEM_ADDR, 10'h200 + 10'(i));
            end
            tick();
        end
        bus.EXT_REQ = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.CORE_READ = 1'b1; bus.CORE_ADDR = 10'h200;
        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b0; bus.EXT_ADDR = 10'h201;
        #1;
        checks++;
        if (ctrl() !== 5'b00011 || bus.MEM_ADDR !== 10'h200) begin
            errors++; $display("FAIL simul_a: got %b/%h exp 00011/200", ctrl(), bus.MEM_ADDR);
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00000 || bus.CORE_RDATA !== 32'hA0) begin
            errors++; $display("FAIL simul_b: got %b/%h exp 00000/000000a0", ctrl(), bus.CORE_RDATA);
        end
        tick();
        bus.CORE_READ = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b10010 || bus.MEM_ADDR !== 10'h201) begin
            errors++; $display("FAIL simul_c: got %b/%h exp 10010/201", ctrl(), bus.MEM_ADDR);
        end
        tick();
        bus.EXT_REQ = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b01000 || bus.EXT_RDATA !== 32'hA1) begin
            errors++; $display("FAIL simul_d: got %b/%h exp 01000/000000a1", ctrl(), bus.EXT_RDATA);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Push the starve count to the limit, then reset inside CORE_RD.
        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b1; bus.EXT_ADDR = 10'h030; bus.EXT_WDATA = 32'h55;
        for (int i = 0; i < 3; i++) begin
            bus.CORE_WRITE = 1'b1; bus.CORE_ADDR = 10'h300 + 10'(i); bus.CORE_WDATA = 32'h77;
            tick();
        end
        bus.CORE_WRITE = 1'b0; bus.CORE_READ = 1'b1; bus.CORE_ADDR = 10'h300;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b00000 || bus.CORE_RDATA !== 32'h0 || bus.MEM_ADDR !== 10'h000) begin
            errors++; $display("FAIL rst_core_rd: got %b/%h/%h exp 00000/0/0", ctrl(), bus.CORE_RDATA, bus.MEM_ADDR);
        end
        rst_n = 1'b1;
        test_contention(10'h340);

        bus.EXT_REQ = 1'b1; bus.EXT_WE = 1'b0; bus.EXT_ADDR = 10'h3FF;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl() !== 5'b00000 || bus.EXT_RDATA !== 32'h0) begin
            errors++; $display("FAIL rst_ext_rd: got %b/%h exp 00000/0", ctrl(), bus.EXT_RDATA);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctrl() !== 5'b00000) begin
            errors++; $display("FAIL rst_release: got %b exp 00000", ctrl());
        end
        tick();
        checks++;
        if (ctrl() !== 5'b00000 || bus.EXT_RDATA !== 32'h0) begin
            errors++; $display("FAIL rst_no_rvalid: got %b/%h exp 00000/0", ctrl(), bus.EXT_RDATA);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[1023] = 32'h12345678;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_store_load();
        test_ext_read();
        test_contention(10'h100);
        test_load_during_ext_read();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
